// File: rtl/eu_cache_arbiter.sv
// eu_cache_arbiter: access controller for the execution-unit operand cache RAM.
// Shares one RAM slot per cycle between the interconnect (writes) and the ALU
// (consuming reads). Tracks per-entry valid/unread state and occupancy,
// back-pressures writes to unread entries, and bounds ALU starvation.
//
// Optional feature macro: EU_CACHE_BYPASS_EN
//   Same-cycle write+read to the same empty entry is forwarded directly from
//   icon_data to the ALU response without touching the RAM.
//
// Ports:
//   clk, reset_n                 clock (rising edge), async active-low reset
//   icon_valid/addr/data         write request        icon_ready (comb)
//   alu_req_valid/addr           read request         alu_req_ready (comb)
//   alu_rsp_valid/hit/data       read response, one cycle after the read grant
//   ram_ce/we/addr/wdata         RAM request (comb), ram_rdata 1-cycle latency
//   occupancy/full/empty         valid unread entry count and its flags
module eu_cache_arbiter #(
   parameter int unsigned DATA_WIDTH   = 16,
   parameter int unsigned IDX_BITS     = 3,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  icon_valid,
   input  logic [IDX_BITS-1:0]   icon_addr,
   input  logic [DATA_WIDTH-1:0] icon_data,
   output logic                  icon_ready,
   input  logic                  alu_req_valid,
   input  logic [IDX_BITS-1:0]   alu_req_addr,
   output logic                  alu_req_ready,
   output logic                  alu_rsp_valid,
   output logic [DATA_WIDTH-1:0] alu_rsp_data,
   output logic                  alu_rsp_hit,
   output logic                  ram_ce,
   output logic                  ram_we,
   output logic [IDX_BITS-1:0]   ram_addr,
   output logic [DATA_WIDTH-1:0] ram_wdata,
   input  logic [DATA_WIDTH-1:0] ram_rdata,
   output logic [IDX_BITS:0]     occupancy,
   output logic                  full,
   output logic                  empty
);

   localparam int unsigned ENTRIES = 1 << IDX_BITS;
   localparam int unsigned OCC_W   = IDX_BITS + 1;
   localparam int unsigned CNT_W   = 4;

   logic [ENTRIES-1:0]    valid;
   logic [OCC_W-1:0]      occ_q;
   logic [CNT_W-1:0]      starve_cnt;
   logic                  rsp_valid_q;
   logic                  rsp_hit_q;
   logic                  rsp_byp_q;
   logic [DATA_WIDTH-1:0] byp_data_q;

   logic icon_elig;
   logic alu_elig;
   logic starved;
   logic grant_wr;
   logic grant_rd;
   logic bypass;
   logic rd_hit;

   // Arbitration: icon preferred unless the ALU has been denied STARVE_LIMIT times.
   always_comb begin
      grant_wr  = 1'b0;
      grant_rd  = 1'b0;
      bypass    = 1'b0;
      icon_elig = icon_valid & ~valid[icon_addr];
      alu_elig  = alu_req_valid;
      starved   = (starve_cnt == CNT_W'(STARVE_LIMIT));
      rd_hit    = valid[alu_req_addr];
      if (reset_n) begin
`ifdef EU_CACHE_BYPASS_EN
         // icon_elig already implies the shared entry is not valid
         bypass = icon_elig & alu_elig & (icon_addr == alu_req_addr);
`endif
         if (!bypass) begin
            if (icon_elig && (!alu_elig || !starved)) begin
               grant_wr = 1'b1;
            end else if (alu_elig) begin
               grant_rd = 1'b1;
            end
         end
      end
   end

   // Handshakes and RAM request; everything idles to zero
   always_comb begin
      icon_ready    = grant_wr | bypass;
      alu_req_ready = grant_rd | bypass;
      ram_ce        = grant_wr | grant_rd;
      ram_we        = grant_wr;
      ram_addr      = '0;
      ram_wdata     = '0;
      if (grant_wr) begin
         ram_addr  = icon_addr;
         ram_wdata = icon_data;
      end else if (grant_rd) begin
         ram_addr = alu_req_addr;
      end
   end

   // Entry state, occupancy, starvation counter and response pipeline
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid       <= '0;
         occ_q       <= '0;
         starve_cnt  <= '0;
         rsp_valid_q <= 1'b0;
         rsp_hit_q   <= 1'b0;
         rsp_byp_q   <= 1'b0;
         byp_data_q  <= '0;
      end else begin
         rsp_valid_q <= grant_rd | bypass;
         rsp_hit_q   <= (grant_rd & rd_hit) | bypass;
         rsp_byp_q   <= bypass;
         if (bypass) begin
            byp_data_q <= icon_data;
         end

         // Write and hit-read never coincide, so occupancy moves by at most one
         if (grant_wr) begin
            valid[icon_addr] <= 1'b1;
            occ_q            <= occ_q + OCC_W'(1);
         end else if (grant_rd && rd_hit) begin
            valid[alu_req_addr] <= 1'b0;
            occ_q               <= occ_q - OCC_W'(1);
         end

         if (grant_rd || bypass) begin
            starve_cnt <= '0;
         end else if (alu_req_valid && (starve_cnt < CNT_W'(STARVE_LIMIT))) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
         end
      end
   end

   assign alu_rsp_valid = rsp_valid_q;
   assign alu_rsp_hit   = rsp_hit_q;
   // RAM data arrives the cycle after the read grant; misses return zero
   assign alu_rsp_data  = rsp_hit_q ? (rsp_byp_q ? byp_data_q : ram_rdata) : '0;
   assign occupancy     = occ_q;
   assign full          = (occ_q == OCC_W'(ENTRIES));
   assign empty         = (occ_q == '0);

endmodule

// File: tb/tb_eu_cache_arbiter.sv
// Testbench for eu_cache_arbiter: behavioural RAM, scoreboard of expected ALU
// responses pushed at read grant and popped when alu_rsp_valid is seen.
module tb_eu_cache_arbiter;

   logic        clk;
   logic        reset_n;
   logic        icon_valid;
   logic [2:0]  icon_addr;
   logic [15:0] icon_data;
   logic        icon_ready;
   logic        alu_req_valid;
   logic [2:0]  alu_req_addr;
   logic        alu_req_ready;
   logic        alu_rsp_valid;
   logic [15:0] alu_rsp_data;
   logic        alu_rsp_hit;
   logic        ram_ce;
   logic        ram_we;
   logic [2:0]  ram_addr;
   logic [15:0] ram_wdata;
   logic [15:0] ram_rdata;
   logic [3:0]  occupancy;
   logic        full;
   logic        empty;

   typedef struct {
      logic        hit;
      logic [15:0] data;
   } exp_t;

   exp_t        sb[$];
   int          n_cmp = 0;
   int          n_err = 0;
   logic [15:0] mem[8];

   eu_cache_arbiter #(
      .DATA_WIDTH  (16),
      .IDX_BITS    (3),
      .STARVE_LIMIT(4)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .icon_valid   (icon_valid),
      .icon_addr    (icon_addr),
      .icon_data    (icon_data),
      .icon_ready   (icon_ready),
      .alu_req_valid(alu_req_valid),
      .alu_req_addr (alu_req_addr),
      .alu_req_ready(alu_req_ready),
      .alu_rsp_valid(alu_rsp_valid),
      .alu_rsp_data (alu_rsp_data),
      .alu_rsp_hit  (alu_rsp_hit),
      .ram_ce       (ram_ce),
      .ram_we       (ram_we),
      .ram_addr     (ram_addr),
      .ram_wdata    (ram_wdata),
      .ram_rdata    (ram_rdata),
      .occupancy    (occupancy),
      .full         (full),
      .empty        (empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model; garbage contents make a zeroed miss response observable
   always @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < 8; i++) mem[i] <= 16'hdead ^ 16'(i);
      end else begin
         if (ram_ce && ram_we) mem[ram_addr] <= ram_wdata;
         if (ram_ce && !ram_we) ram_rdata <= mem[ram_addr];
      end
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Response monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (alu_rsp_valid) begin
            if (sb.size() == 0) begin
               check_val("rsp_unexpected", 32'(alu_rsp_valid), 32'd0);
            end else begin
               e = sb.pop_front();
               check_val("rsp_hit", 32'(alu_rsp_hit), 32'(e.hit));
               check_val("rsp_data", 32'(alu_rsp_data), 32'(e.data));
            end
         end
      end
   end

   task automatic push_exp(input logic h, input logic [15:0] d);
      exp_t e;
      e.hit  = h;
      e.data = d;
      sb.push_back(e);
   endtask

   // Write request; called at a negedge, returns at the negedge after acceptance
   task automatic wr(input logic [2:0] a, input logic [15:0] d);
      int n;
      n = 0;
      icon_valid = 1'b1;
      icon_addr  = a;
      icon_data  = d;
      #1;
      while (!icon_ready && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      check_val("wr_ready", 32'(icon_ready), 32'd1);
      check_val("wr_ram_cewe", 32'({ram_ce, ram_we}), 32'd3);
      check_val("wr_ram_addr", 32'(ram_addr), 32'(a));
      check_val("wr_ram_wdata", 32'(ram_wdata), 32'(d));
      @(negedge clk);
      icon_valid = 1'b0;
   endtask

   // Read request; expected response queued on grant
   task automatic rd(input logic [2:0] a, input logic eh, input logic [15:0] ed);
      int n;
      n = 0;
      alu_req_valid = 1'b1;
      alu_req_addr  = a;
      #1;
      while (!alu_req_ready && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      check_val("rd_ready", 32'(alu_req_ready), 32'd1);
      check_val("rd_ram_cewe", 32'({ram_ce, ram_we}), 32'd2);
      check_val("rd_ram_addr", 32'(ram_addr), 32'(a));
      if (alu_req_ready) push_exp(eh, ed);
      @(negedge clk);
      alu_req_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
      $fatal(1, "watchdog");
   end

   initial begin
      int wi;
      logic exp_alu;

      reset_n       = 1'b0;
      icon_valid    = 1'b1;
      icon_addr     = 3'd0;
      icon_data     = 16'h1111;
      alu_req_valid = 1'b1;
      alu_req_addr  = 3'd0;
      repeat (3) @(negedge clk);
      #1;
      check_val("rst_icon_ready", 32'(icon_ready), 32'd0);
      check_val("rst_alu_ready", 32'(alu_req_ready), 32'd0);
      check_val("rst_ram_ce", 32'(ram_ce), 32'd0);
      check_val("rst_occupancy", 32'(occupancy), 32'd0);
      check_val("rst_empty", 32'(empty), 32'd1);
      check_val("rst_full", 32'(full), 32'd0);
      check_val("rst_rsp_valid", 32'(alu_rsp_valid), 32'd0);
      check_val("rst_rsp_data", 32'(alu_rsp_data), 32'd0);
      icon_valid    = 1'b0;
      alu_req_valid = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      #1;
      check_val("idle_ram_ce", 32'(ram_ce), 32'd0);
      check_val("idle_ram_addr", 32'(ram_addr), 32'd0);

      // Write then read back one entry
      @(negedge clk);
      wr(3'd2, 16'h1234);
      check_val("t1_occ_after_wr", 32'(occupancy), 32'd1);
      rd(3'd2, 1'b1, 16'h1234);
      check_val("t1_occ_after_rd", 32'(occupancy), 32'd0);

      // Miss on empty cache
      rd(3'd5, 1'b0, 16'h0000);
      check_val("t2_occ", 32'(occupancy), 32'd0);
      check_val("t2_empty", 32'(empty), 32'd1);

      // Fill, block a write to an unread entry, free it, then accept
      for (int i = 0; i < 8; i++) wr(3'(i), 16'h0100 + 16'(i));
      check_val("t3_full", 32'(full), 32'd1);
      check_val("t3_occ_full", 32'(occupancy), 32'd8);
      icon_valid = 1'b1;
      icon_addr  = 3'd0;
      icon_data  = 16'habcd;
      for (int k = 0; k < 3; k++) begin
         #1;
         check_val("t3_full_blocks", 32'(icon_ready), 32'd0);
         @(negedge clk);
      end
      alu_req_valid = 1'b1;
      alu_req_addr  = 3'd0;
      #1;
      check_val("t3_rd_ready", 32'(alu_req_ready), 32'd1);
      check_val("t3_icon_still_blocked", 32'(icon_ready), 32'd0);
      if (alu_req_ready) push_exp(1'b1, 16'h0100);
      @(negedge clk);
      alu_req_valid = 1'b0;
      #1;
      check_val("t3_icon_accepted", 32'(icon_ready), 32'd1);
      @(negedge clk);
      icon_valid = 1'b0;
      check_val("t3_occ_refull", 32'(occupancy), 32'd8);
      for (int i = 0; i < 8; i++) rd(3'(i), 1'b1, (i == 0) ? 16'habcd : 16'h0100 + 16'(i));
      check_val("t3_empty", 32'(empty), 32'd1);

      // Continuous contention: 4 icon grants then 1 ALU grant
      wi = 0;
      icon_valid    = 1'b1;
      alu_req_valid = 1'b1;
      alu_req_addr  = 3'd7;
      for (int cyc = 0; cyc < 10; cyc++) begin
         icon_addr = 3'(wi);
         icon_data = 16'h2000 + 16'(wi);
         #1;
         exp_alu = ((cyc % 5) == 4);
         check_val("t4_alu_grant", 32'(alu_req_ready), 32'(exp_alu));
         check_val("t4_icon_grant", 32'(icon_ready), 32'(!exp_alu));
         if (alu_req_ready) push_exp(cyc == 9, (cyc == 9) ? 16'h2007 : 16'h0000);
         if (icon_ready) wi++;
         @(negedge clk);
      end
      icon_valid    = 1'b0;
      alu_req_valid = 1'b0;
      check_val("t4_occ", 32'(occupancy), 32'd7);
      for (int i = 0; i < 7; i++) rd(3'(i), 1'b1, 16'h2000 + 16'(i));
      check_val("t4_empty", 32'(empty), 32'd1);

      // Same-address write and read in one cycle
      icon_valid    = 1'b1;
      icon_addr     = 3'd3;
      icon_data     = 16'h5a5a;
      alu_req_valid = 1'b1;
      alu_req_addr  = 3'd3;
      #1;
`ifdef EU_CACHE_BYPASS_EN
      check_val("t5_byp_icon_ready", 32'(icon_ready), 32'd1);
      check_val("t5_byp_alu_ready", 32'(alu_req_ready), 32'd1);
      check_val("t5_byp_ram_ce", 32'(ram_ce), 32'd0);
      if (alu_req_ready) push_exp(1'b1, 16'h5a5a);
      @(negedge clk);
      icon_valid    = 1'b0;
      alu_req_valid = 1'b0;
      check_val("t5_byp_occ", 32'(occupancy), 32'd0);
`else
      check_val("t5_icon_ready", 32'(icon_ready), 32'd1);
      check_val("t5_alu_wait", 32'(alu_req_ready), 32'd0);
      @(negedge clk);
      icon_valid = 1'b0;
      check_val("t5_occ_mid", 32'(occupancy), 32'd1);
      #1;
      check_val("t5_alu_ready", 32'(alu_req_ready), 32'd1);
      if (alu_req_ready) push_exp(1'b1, 16'h5a5a);
      @(negedge clk);
      alu_req_valid = 1'b0;
      check_val("t5_occ", 32'(occupancy), 32'd0);
`endif

      // Reset right after a read grant drops the in-flight response
      @(negedge clk);
      wr(3'd1, 16'h7777);
      wr(3'd4, 16'h4444);
      check_val("t6_occ_pre", 32'(occupancy), 32'd2);
      alu_req_valid = 1'b1;
      alu_req_addr  = 3'd1;
      #1;
      check_val("t6_rd_ready", 32'(alu_req_ready), 32'd1);
      @(posedge clk);
      #1;
      reset_n       = 1'b0;
      alu_req_valid = 1'b0;
      @(negedge clk);
      check_val("t6_rsp_dropped", 32'(alu_rsp_valid), 32'd0);
      check_val("t6_occ_rst", 32'(occupancy), 32'd0);
      check_val("t6_empty_rst", 32'(empty), 32'd1);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check_val("t6_rsp_after_rel", 32'(alu_rsp_valid), 32'd0);
      rd(3'd4, 1'b0, 16'h0000);
      check_val("t6_occ_end", 32'(occupancy), 32'd0);

      repeat (2) @(negedge clk);
      check_val("sb_drained", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
